spi_slave_word: RTL and testbench

- Parametrised successor to the team's bit-level SPI echo slave.
- Runs entirely in the `clk` domain: oversamples SCLK, MOSI and SS through synchronizers.
- Supports all four SPI modes, configurable word width and bit order, and back-to-back words within one SS assertion.
- Provides a valid pulse for received words and a one-deep valid/ready TX holding register toward the fabric (face-recognition host link).

---
 rtl/spi_slave_word_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_word.sv | 159 +++++++++++++++
 tb/tb_spi_slave_word.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_word_pkg.sv
// Shared SPI slave definitions: mode encodings, FSM states, synchronizer depth.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_slave_word_pkg;

  // {CPOL, CPHA} pairs
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one-clk rise/fall pulses.
// Latency: pulse is visible SYNC_STAGES clk after the pin changes.
// Backpressure: none.
module spi_sync_edge
  import spi_slave_word_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_word.sv
// Word-level SPI slave, all four modes, oversampled in clk; SPI_SLAVE_ECHO_EN echoes the last RX word on underrun.
// Latency: o_rx_valid pulses 3 clk after the final sample edge at the pin.
// Backpressure: none on RX; TX is a one-deep valid/ready holding register, TX_IDLE shifted when it is empty.
module spi_slave_word
  import spi_slave_word_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] TX_IDLE   = '0
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic             i_ss,
  output logic             o_miso,
  output logic             o_miso_oe,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic             o_tx_underrun,
  output logic             o_busy
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rx_sh_q, rx_sh_d, tx_sh_q, hold_q, tx_fill, idle_word;
  logic               hold_full_q, rx_valid_q, underrun_q;
  logic               word_start, advance, rx_done;
  logic               sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic               lead_edge, trail_edge, sample_edge, shift_edge;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic               mosi_s;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_d    (i_sclk),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_d    (i_ss),
    .o_rise (ss_rise),
    .o_fall (ss_fall)
  );

  always_ff @(posedge clk) begin
    if (i_rst) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

`ifdef SPI_SLAVE_ECHO_EN
  assign idle_word = rx_done ? rx_sh_d : o_rx_data;
`else
  assign idle_word = TX_IDLE;
`endif
  assign tx_fill = hold_full_q ? hold_q : idle_word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    word_start = 1'b0;
    advance    = 1'b0;
    rx_done    = 1'b0;
    o_miso     = 1'b0;
    o_miso_oe  = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          word_start = 1'b1;
        end
      end
      ACTIVE: begin
        o_miso_oe = 1'b1;
        o_miso    = MSB_FIRST ? tx_sh_q[WIDTH-1] : tx_sh_q[0];
        o_busy    = (cnt_q != '0);
        if (sample_edge) begin
          rx_sh_d = MSB_FIRST ? {rx_sh_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            rx_done = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A shift edge at count 0 is a word boundary: CPHA=0 loads the next
        // word there, CPHA=1 just leaves the already-presented bit 0 alone.
        if (shift_edge) begin
          if (cnt_q == '0) word_start = !CPHA;
          else             advance    = 1'b1;
        end
        if (CPHA && rx_done) word_start = 1'b1;
        if (ss_rise) begin
          state_d    = IDLE;
          cnt_d      = '0;
          word_start = 1'b0;
          advance    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      o_rx_data   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_done;
      underrun_q <= word_start && !hold_full_q;
      if (rx_done) o_rx_data <= rx_sh_d;
      if (word_start)   tx_sh_q <= tx_fill;
      else if (advance) tx_sh_q <= MSB_FIRST ? {tx_sh_q[WIDTH-2:0], 1'b0} : {1'b0, tx_sh_q[WIDTH-1:1]};
      // A load only happens when empty, so a same-clk word start has already
      // taken TX_IDLE and the freshly loaded word stays held.
      if (i_tx_valid && !hold_full_q) begin
        hold_q      <= i_tx_data;
        hold_full_q <= 1'b1;
      end else if (word_start) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign o_rx_valid    = rx_valid_q;
  assign o_tx_underrun = underrun_q;
  assign o_tx_ready    = !hold_full_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: five instances (modes 0-3, MSB/LSB, widths 8/12/16) driven by a behavioural SPI master.
// Expected words come from the master's own word lists and the fabric queue order.
module tb_spi_slave_word;

  localparam int N = 5;
  localparam int         WID  [N] = '{8, 16, 16, 16, 12};
  localparam bit         POL  [N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit         PHA  [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit         MSBF [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [15:0] TXI [N] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h05A3};
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk [N];
  logic        mosi [N];
  logic        ss   [N];
  logic [15:0] tx_d [N];
  logic        tx_vld [N];
  logic        miso [N];
  logic        oe [N];
  logic        rx_vld [N];
  logic        tx_rdy [N];
  logic        und [N];
  logic        busy [N];
  logic [15:0] rx_d [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [WID[g]-1:0] rxd;
    spi_slave_word #(
      .WIDTH     (WID[g]),
      .CPOL      (POL[g]),
      .CPHA      (PHA[g]),
      .MSB_FIRST (MSBF[g]),
      .TX_IDLE   (TXI[g][WID[g]-1:0])
    ) dut (
      .clk           (clk),
      .i_rst         (rst),
      .i_sclk        (sclk[g]),
      .i_mosi        (mosi[g]),
      .i_ss          (ss[g]),
      .o_miso        (miso[g]),
      .o_miso_oe     (oe[g]),
      .o_rx_data     (rxd),
      .o_rx_valid    (rx_vld[g]),
      .i_tx_data     (tx_d[g][WID[g]-1:0]),
      .i_tx_valid    (tx_vld[g]),
      .o_tx_ready    (tx_rdy[g]),
      .o_tx_underrun (und[g]),
      .o_busy        (busy[g])
    );
    assign rx_d[g] = 16'(rxd);
  end

  int          checks = 0;
  int          errors = 0;
  int          fidx = 0;
  logic [15:0] feed_q [$];
  bit          acc = 1'b0;
  int          rxv_cnt [N];
  int          und_cnt [N];
  logic [15:0] rx_q [N][$];
  logic [15:0] model_rx [N];
  logic [15:0] m_out [4];
  logic [15:0] m_in  [4];
  logic [15:0] q_words [4];

  // Fabric feeder and output monitors, all away from the active edge.
  always @(negedge clk) begin
    if (acc && feed_q.size() > 0) void'(feed_q.pop_front());
    for (int i = 0; i < N; i++) begin
      tx_vld[i] = 1'b0;
      if (rx_vld[i] === 1'b1) begin
        rxv_cnt[i]++;
        rx_q[i].push_back(rx_d[i]);
      end
      if (und[i] === 1'b1) und_cnt[i]++;
    end
    if (feed_q.size() > 0) begin
      tx_vld[fidx] = 1'b1;
      tx_d[fidx]   = feed_q[0];
    end
    acc = (feed_q.size() > 0) && (tx_rdy[fidx] === 1'b1) && !rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  function automatic int bpos(input int idx, input int b);
    return MSBF[idx] ? (WID[idx] - 1 - b) : b;
  endfunction

  // SPI master: nw words from m_out, captured MISO into m_in. The last clock
  // edge and SS release coincide. stop_bits > 0 aborts after that many bits.
  task automatic spi_xfer(input int idx, input int nw, input int stop_bits, input bit use_rst);
    int w;
    int total;
    w = WID[idx];
    total = nw * w;
    for (int i = 0; i < 4; i++) m_in[i] = '0;
    ss[idx] = 1'b0;
    if (!PHA[idx]) mosi[idx] = m_out[0][bpos(idx, 0)];
    half();
    for (int k = 0; k < total; k++) begin
      int wi;
      int b;
      bit last;
      wi = k / w;
      b = k % w;
      last = (k == total - 1);
      if (PHA[idx]) begin
        sclk[idx] = !POL[idx];
        mosi[idx] = m_out[wi][bpos(idx, b)];
        half();
        m_in[wi][bpos(idx, b)] = miso[idx];
        sclk[idx] = POL[idx];
        if (last) ss[idx] = 1'b1;
        half();
      end else begin
        m_in[wi][bpos(idx, b)] = miso[idx];
        sclk[idx] = !POL[idx];
        half();
        sclk[idx] = POL[idx];
        if (last) ss[idx] = 1'b1;
        else      mosi[idx] = m_out[(k + 1) / w][bpos(idx, (k + 1) % w)];
        half();
      end
      if (k + 1 == stop_bits) begin
        chk("busy_mid_word", 32'(busy[idx]), 32'd1);
        if (use_rst) rst = 1'b1;
        ss[idx] = 1'b1;
        return;
      end
    end
    half();
    half();
  endtask

  // Queue nq fabric words, run nw words, compare both directions against the model.
  task automatic transfer_check(input int idx, input int nw, input int nq, input string tag);
    int rx0;
    int un0;
    logic [15:0] exp;
    logic [15:0] got;
    fidx = idx;
    for (int j = 0; j < nq; j++) feed_q.push_back(q_words[j]);
    repeat (6) @(negedge clk);
    rx0 = rxv_cnt[idx];
    un0 = und_cnt[idx];
    spi_xfer(idx, nw, -1, 1'b0);
    chk({tag, "_rx_count"}, 32'(rxv_cnt[idx] - rx0), 32'(nw));
    chk({tag, "_underruns"}, 32'(und_cnt[idx] - un0), 32'(nw - nq));
    for (int wi = 0; wi < nw; wi++) begin
      if (wi < nq) exp = q_words[wi];
`ifdef SPI_SLAVE_ECHO_EN
      else exp = (wi == 0) ? model_rx[idx] : m_out[wi - 1];
`else
      else exp = TXI[idx];
`endif
      chk($sformatf("%s_miso_word%0d", tag, wi), 32'(m_in[wi]), 32'(exp));
      got = (rx_q[idx].size() > 0) ? rx_q[idx].pop_front() : 16'hxxxx;
      chk($sformatf("%s_rx_word%0d", tag, wi), 32'(got), 32'(m_out[wi]));
    end
    chk({tag, "_tx_ready"}, 32'(tx_rdy[idx]), 32'd1);
    chk({tag, "_miso_oe_idle"}, 32'(oe[idx]), 32'd0);
    model_rx[idx] = m_out[nw - 1];
    feed_q.delete();
  endtask

  task automatic check_reset_state(input int i, input string tag);
    chk($sformatf("%s%0d_miso", tag, i), 32'(miso[i]), 32'd0);
    chk($sformatf("%s%0d_oe", tag, i), 32'(oe[i]), 32'd0);
    chk($sformatf("%s%0d_rx_data", tag, i), 32'(rx_d[i]), 32'd0);
    chk($sformatf("%s%0d_rx_valid", tag, i), 32'(rx_vld[i]), 32'd0);
    chk($sformatf("%s%0d_tx_ready", tag, i), 32'(tx_rdy[i]), 32'd1);
    chk($sformatf("%s%0d_underrun", tag, i), 32'(und[i]), 32'd0);
    chk($sformatf("%s%0d_busy", tag, i), 32'(busy[i]), 32'd0);
  endtask

  initial begin
    int rx0;
    int un0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      sclk[i] = POL[i];
      ss[i] = 1'b1;
      mosi[i] = 1'b0;
      model_rx[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check_reset_state(i, "reset_inst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0, 8 bit
    m_out[0] = 16'h003C; q_words[0] = 16'h00A5;
    transfer_check(0, 1, 1, "mode0");

    // Modes 1..3, 16 bit
    for (int i = 1; i <= 3; i++) begin
      m_out[0] = 16'hBEEF; q_words[0] = 16'h1234;
      transfer_check(i, 1, 1, $sformatf("mode%0d", i));
    end

    // Back-to-back under one SS
    m_out[0] = 16'h0011; m_out[1] = 16'h0022; m_out[2] = 16'h0033;
    q_words[0] = 16'h0044; q_words[1] = 16'h0055;
    transfer_check(0, 3, 2, "b2b");

    // Abort after 5 of 8 bits, then a clean word
    fidx = 0;
    rx0 = rxv_cnt[0];
    m_out[0] = 16'h00F0;
    spi_xfer(0, 1, 5, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_no_rx_valid", 32'(rxv_cnt[0] - rx0), 32'd0);
    chk("abort_busy_low", 32'(busy[0]), 32'd0);
    chk("abort_rx_data_kept", 32'(rx_d[0]), 32'(model_rx[0]));
    m_out[0] = 16'h0081;
    transfer_check(0, 1, 0, "after_abort");

    // LSB first, 12 bit
    m_out[0] = 16'h0ABC;
    transfer_check(4, 1, 0, "lsb12");

    // Reset at bit 4 with a word still held
    fidx = 0;
    feed_q.push_back(16'h00C3);
    feed_q.push_back(16'h003C);
    repeat (6) @(negedge clk);
    rx0 = rxv_cnt[0];
    un0 = und_cnt[0];
    m_out[0] = 16'h0096;
    spi_xfer(0, 1, 4, 1'b1);
    @(negedge clk);
    check_reset_state(0, "midword_reset");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    feed_q.delete();
    model_rx[0] = '0;
    repeat (4) @(negedge clk);
    chk("midword_reset_no_rx_valid", 32'(rxv_cnt[0] - rx0), 32'd0);
    chk("midword_reset_no_underrun", 32'(und_cnt[0] - un0), 32'd0);
    m_out[0] = 16'h005A; q_words[0] = 16'h00E7;
    transfer_check(0, 1, 1, "after_reset");

    // Randomized transfers across all instances
    for (int r = 0; r < 10; r++) begin
      int idx;
      int nw;
      int nq;
      idx = $urandom_range(0, N - 1);
      nw = $urandom_range(1, 3);
      nq = $urandom_range(0, nw);
      for (int j = 0; j < 4; j++) begin
        m_out[j]   = 16'($urandom_range(0, (1 << WID[idx]) - 1));
        q_words[j] = 16'($urandom_range(0, (1 << WID[idx]) - 1));
      end
      transfer_check(idx, nw, nq, $sformatf("rand%0d_inst%0d", r, idx));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
